// File: rtl/fir_decim_avg.sv
// Block-average decimator for the FIR output stream.
// Results are queued in a small FWFT FIFO with a registered valid/ready head.
module fir_decim_avg #(
  parameter int DW         = 10,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DW-1:0]                 din,
  input  logic                          din_valid,
  output logic [DW-1:0]                 dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun
);

  localparam int SW = $clog2(DECIM);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = DW + SW;
  localparam logic [SW-1:0] CNT_LAST = SW'(DECIM - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  logic [CW-1:0]  acc;
  logic [SW-1:0]  cnt;
  logic [CW-1:0]  sum;
  logic [DW-1:0]  result;
  logic           blk_done;
  logic           full;
  logic           pop;
  logic           push_ok;
  logic           drop;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  rd_ptr_n;
  logic [LW-1:0]  level_n;
  logic [DW-1:0]  head_n;
  logic [DW-1:0]  mem [FIFO_DEPTH];

  always_comb begin
    sum      = acc + {{SW{1'b0}}, din};
    result   = sum[CW-1:SW];
    blk_done = din_valid && (cnt == CNT_LAST);
    full     = (fifo_level == LVL_FULL);
    pop      = dout_valid && dout_ready;
    push_ok  = blk_done && (!full || pop);
    drop     = blk_done && full && !pop;
    rd_ptr_n = pop ? rd_ptr + 1'b1 : rd_ptr;
    level_n  = fifo_level;
    if (push_ok && !pop) level_n = fifo_level + 1'b1;
    if (pop && !push_ok) level_n = fifo_level - 1'b1;
    // Head after this edge may be the entry being written right now.
    head_n = mem[rd_ptr_n];
    if (push_ok && (wr_ptr == rd_ptr_n)) head_n = result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (din_valid) begin
      if (blk_done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_ptr_n;
      fifo_level <= level_n;
      dout_valid <= (level_n != '0);
      dout       <= (level_n != '0) ? head_n : '0;
      if (drop) overrun <= 1'b1;
    end
  end

endmodule
